// File: rtl/axi_read_responder.sv
// axi_read_responder: single-outstanding AXI4 read slave backed by a preloadable 64-bit word store.
// Define AXI_RD_RESP_SLVERR_EN to return SLVERR/zero data for word indices beyond MEM_WORDS.
module axi_read_responder #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_WORDS  = 1024,
  parameter int LAT        = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2;
  logic [1:0] state, burst;
  logic [3:0] cnt;
  logic [7:0] beat, len;
  logic [2:0] size;
  logic [ADDR_WIDTH-1:0] addr, sz, win, inc, nxt;
  logic wrap_ok, load, oob;
  logic [AW-1:0] idx;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  assign s_axi_arready = state == IDLE && !reset;
`ifdef AXI_RD_RESP_SLVERR_EN
  assign oob = |addr[ADDR_WIDTH-1:AW+3];
`else
  assign oob = 1'b0;
`endif
  // addr always holds the address of the next beat to be loaded into the R register
  always_comb begin
    sz = ADDR_WIDTH'(1) << size;
    win = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
    inc = addr + sz;
    wrap_ok = burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    nxt = burst == 2'b00 ? addr
        : wrap_ok ? (addr & ~(win - ADDR_WIDTH'(1))) | (inc & (win - ADDR_WIDTH'(1)))
        : inc;
    idx = addr[AW+2:3];
    load = (state == WAIT && cnt == 4'd1) || (state == BURST && s_axi_rready && !s_axi_rlast);
  end
  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      beat <= 8'd0;
      len <= 8'd0;
      size <= 3'd0;
      burst <= 2'd0;
      addr <= '0;
      s_axi_rid <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
      s_axi_rlast <= 1'b0;
      s_axi_rvalid <= 1'b0;
    end else begin
      if (state == IDLE && s_axi_arvalid) begin
        state <= WAIT;
        cnt <= 4'(LAT);
        s_axi_rid <= s_axi_arid;
        addr <= s_axi_araddr;
        len <= s_axi_arlen;
        size <= s_axi_arsize;
        burst <= s_axi_arburst;
      end
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          state <= BURST;
          s_axi_rvalid <= 1'b1;
        end
      end
      if (state == BURST && s_axi_rready && s_axi_rlast) begin
        state <= IDLE;
        s_axi_rvalid <= 1'b0;
        s_axi_rlast <= 1'b0;
      end
      if (load) begin
        addr <= nxt;
        s_axi_rdata <= oob ? '0 : mem[idx];
        s_axi_rresp <= oob ? 2'b10 : 2'b00;
        s_axi_rlast <= (state == WAIT ? 8'd0 : beat + 8'd1) == len;
        beat <= state == WAIT ? 8'd0 : beat + 8'd1;
      end
    end
endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 13, AR/R ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, fixed at 64, R data width (8-byte word).
REQ-004 SHALL have parameter MEM_WORDS, default 1024, backing-store depth in 64-bit words; must be a power of two.
REQ-005 SHALL have parameter LAT, default 2, cycles from AR handshake to first rvalid; must be 1..15.
REQ-006 SHALL have ports clk in 1 clock; reset in 1 (reset reset, asynchronous, active-high; clock clk).
REQ-007 SHALL have AR ports: s_axi_arid in ID_WIDTH; s_axi_araddr in ADDR_WIDTH; s_axi_arlen in 8; s_axi_arsize in 3; s_axi_arburst in 2; s_axi_arvalid in 1; s_axi_arready out 1.
REQ-008 SHALL have R ports: s_axi_rid out ID_WIDTH; s_axi_rdata out 64; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-009 SHALL have preload ports: mem_we in 1; mem_waddr in log2(MEM_WORDS), word index; mem_wdata in 64.

Function
REQ-010 SHALL implement FSM IDLE -> WAIT -> BURST -> IDLE; one outstanding burst only.
REQ-011 IDLE: arready=1; on arvalid&arready capture arid, araddr, arlen, arsize, arburst, load latency counter with LAT, go to WAIT.
REQ-012 WAIT/BURST: arready=0; new AR requests are stalled, not dropped.
REQ-013 WAIT: decrement counter each cycle; rvalid SHALL first rise exactly LAT cycles after the AR handshake edge; enter BURST.
REQ-014 BURST: rvalid held high; rid, rdata, rresp, rlast SHALL be stable while rvalid&!rready.
REQ-015 On rvalid&rready with !rlast: advance beat; next beat presented the following cycle (one beat per cycle at full throughput, no bubbles).
REQ-016 On rvalid&rready&rlast: rvalid=0, return to IDLE; arready=1 in the next cycle.
REQ-017 rlast SHALL be 1 exactly on beat index == captured arlen (arlen+1 beats total).
REQ-018 Beat address: FIXED (00) constant; INCR (01) += 1<<arsize; WRAP (10) wraps within an aligned window of (arlen+1)<<arsize bytes; reserved 11 treated as INCR.
REQ-019 WRAP with arlen not in {1,3,7,15} SHALL behave as INCR.
REQ-020 rdata = mem[addr[..3]] (full 64-bit word); narrow arsize does not mask bytes.
REQ-021 rid = captured arid on every beat; rresp=00 (OKAY) unless REQ-027 applies.
REQ-022 Preload write takes effect at the clock edge; a write to a word in the same cycle that word is loaded into the R register SHALL yield the old data.
REQ-023 Backing store contents are not cleared by reset.

Reset
REQ-024 Reset SHALL force IDLE; arready=0 while reset asserted, 1 in the first cycle after deassertion.
REQ-025 Reset SHALL clear rvalid, rlast, rresp, rid, rdata to 0 and the latency and beat counters to 0.
REQ-026 Reset mid-burst SHALL abort the burst; no remaining beats are issued.

Configuration
REQ-027 With AXI_RD_RESP_SLVERR_EN defined: beats whose word index >= MEM_WORDS return rresp=10 (SLVERR), rdata=0; burst length and rlast unchanged.
REQ-028 Without AXI_RD_RESP_SLVERR_EN: word index taken modulo MEM_WORDS; rresp always 00.

Verification
REQ-029 Preload mem[i]=i*0x11; AR addr 0x40, len 7, size 3, burst 10, id 5 -> beats words 8..15 in order, rid 5, rlast on 8th, first rvalid 2 cycles after AR handshake.
REQ-030 WRAP critical-word-first: addr 0x58, len 7, size 3 -> words 11,12,13,14,15,8,9,10; rlast with word 10.
REQ-031 INCR addr 0x0, len 3 with rready toggling 1,0,0,1,... -> data stable during stalls, 4 beats, no loss or duplicate.
REQ-032 Second arvalid held during burst -> arready 0 until cycle after rlast handshake, then accepted; FIXED burst len 3 at 0x20 returns word 4 four times.
REQ-033 Macro defined, MEM_WORDS 1024: INCR addr 0x1FF8, len 1 -> beat0 word 1023 rresp 00, beat1 rresp 10 rdata 0; undefined -> beat1 = word 0, rresp 00.
REQ-034 Assert reset after beat 3 of an 8-beat burst -> rvalid 0 immediately, no further beats; next AR after reset served normally.
